// File: rtl/vga_pixel_writer_pkg.sv
// Shared types and constants for the VGA pixel write engine.
// The CLEAR state exists only when VGA_PIXEL_WRITER_CLEAR_EN is defined.
package vga_pixel_writer_pkg;

    // Field widths of a queued command; upper bounds for the top's X_W/Y_W/COLOR_W.
    localparam int CMD_X_W     = 9;
    localparam int CMD_Y_W     = 8;
    localparam int CMD_COLOR_W = 8;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_FULL = 2;
    localparam int STAT_ERR  = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE
`ifdef VGA_PIXEL_WRITER_CLEAR_EN
        ,
        S_CLEAR
`endif
    } state_t;

    typedef struct packed {
        logic [CMD_X_W-1:0]     x;
        logic [CMD_Y_W-1:0]     y;
        logic [CMD_COLOR_W-1:0] color;
    } pix_cmd_t;

endpackage

// File: rtl/vga_pixel_writer_if.sv
// Avalon-MM-style write-only master port towards framebuffer memory.
interface vga_pixel_writer_if #(
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 8
);
    logic [ADDR_W-1:0]  address;
    logic [COLOR_W-1:0] writedata;
    logic               write;
    logic               waitrequest;

    modport master (output address, writedata, write, input waitrequest);
    modport slave  (input address, writedata, write, output waitrequest);
endinterface

// File: rtl/pixel_cmd_fifo.sv
// Synchronous show-ahead FIFO: head always presents the oldest entry.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module pixel_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: non-blocking assignments on every flop so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vga_pixel_writer.sv
// Pixel write engine: queues (x, y, colour) commands and writes them to the framebuffer.
// Define VGA_PIXEL_WRITER_CLEAR_EN to add the clear-screen fill (CLEAR state).
module vga_pixel_writer
    import vga_pixel_writer_pkg::*;
#(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int X_W        = CMD_X_W,
    parameter int Y_W        = CMD_Y_W,
    parameter int COLOR_W    = CMD_COLOR_W,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               cmd_clear,
    input  logic               err_clr,
    vga_pixel_writer_if.master fb,
    output logic [3:0]         status
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           state, state_nx;
    pix_cmd_t         cmd_in, fifo_head, cur_cmd;
    logic [CNT_W-1:0] fifo_count, count_nx;
    logic             fifo_full, fifo_empty;
    logic             in_range, push, pop, write_done;
    logic             clear_start, clear_busy, done_event, err_event;
    logic [3:0]       status_nx;

    assign cmd_in.x     = CMD_X_W'(cmd_x);
    assign cmd_in.y     = CMD_Y_W'(cmd_y);
    assign cmd_in.color = CMD_COLOR_W'(cmd_color);

    pixel_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pix_cmd_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (cmd_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef VGA_PIXEL_WRITER_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    // status[STAT_BUSY] is exact for the current cycle, so it gates clear acceptance.
    assign clear_start = cmd_clear && !status[STAT_BUSY];
    assign clear_busy  = cmd_clear && status[STAT_BUSY];
    assign fb.write    = (state == S_WRITE) || (state == S_CLEAR);
`else
    logic unused_clear;
    assign unused_clear = cmd_clear;
    assign clear_start  = 1'b0;
    assign clear_busy   = 1'b0;
    assign fb.write     = (state == S_WRITE);
`endif

    assign write_done = fb.write && !fb.waitrequest;
    assign in_range   = (int'(cmd_x) < H_RES) && (int'(cmd_y) < V_RES);
    assign push       = cmd_valid && in_range && (!fifo_full || pop);
    assign err_event  = (cmd_valid && !push) || clear_busy;
    assign count_nx   = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign done_event = (state != S_IDLE) && (state_nx == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = S_LOAD;
                end
`ifdef VGA_PIXEL_WRITER_CLEAR_EN
                if (clear_start) state_nx = S_CLEAR;
`endif
            end
            S_LOAD: state_nx = S_WRITE;
            S_WRITE: begin
                if (write_done) begin
                    pop      = !fifo_empty;
                    state_nx = fifo_empty ? S_IDLE : S_LOAD;
                end
            end
`ifdef VGA_PIXEL_WRITER_CLEAR_EN
            S_CLEAR: begin
                if (write_done && fb.address == LAST_ADDR) begin
                    pop      = !fifo_empty;
                    state_nx = fifo_empty ? S_IDLE : S_LOAD;
                end
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // Status is registered from next-cycle values so it tracks state and FIFO exactly.
    always_comb begin
        status_nx            = status;
        status_nx[STAT_BUSY] = (count_nx != '0) || (state_nx != S_IDLE);
        if (push || clear_start) status_nx[STAT_DONE] = 1'b0;
        else if (done_event)     status_nx[STAT_DONE] = 1'b1;
        status_nx[STAT_FULL] = (count_nx == CNT_W'(FIFO_DEPTH));
        status_nx[STAT_ERR]  = err_event || (status[STAT_ERR] && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_cmd      <= '0;
            fb.address   <= '0;
            fb.writedata <= '0;
            status       <= '0;
        end else begin
            status <= status_nx;
            if (pop) cur_cmd <= fifo_head;
            if (state == S_LOAD) begin
                fb.address   <= ADDR_W'(cur_cmd.y) * ADDR_W'(H_RES) + ADDR_W'(cur_cmd.x);
                fb.writedata <= COLOR_W'(cur_cmd.color);
            end
`ifdef VGA_PIXEL_WRITER_CLEAR_EN
            if (clear_start) begin
                fb.address   <= '0;
                fb.writedata <= cmd_color;
            end else if (state == S_CLEAR && write_done && fb.address != LAST_ADDR) begin
                fb.address <= fb.address + ADDR_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Directed bench for vga_pixel_writer; adds a 4x2 clear test when VGA_PIXEL_WRITER_CLEAR_EN is set.
module tb_vga_pixel_writer;
    import vga_pixel_writer_pkg::*;

    localparam int ADDR_W  = 17;
    localparam int COLOR_W = 8;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic [X_W-1:0]     cmd_x = '0;
    logic [Y_W-1:0]     cmd_y = '0;
    logic [COLOR_W-1:0] cmd_color = '0;
    logic               cmd_clear = 1'b0;
    logic               err_clr = 1'b0;
    logic [3:0]         status;

    int total = 0;
    int bad   = 0;
    int n0;
    int n;

    logic [ADDR_W-1:0]  wa_q [$];
    logic [COLOR_W-1:0] wd_q [$];

    vga_pixel_writer_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) fb ();

    vga_pixel_writer #(
        .H_RES(320), .V_RES(240), .X_W(X_W), .Y_W(Y_W),
        .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_color (cmd_color),
        .cmd_clear (cmd_clear),
        .err_clr   (err_clr),
        .fb        (fb),
        .status    (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && fb.write && !fb.waitrequest) begin
            wa_q.push_back(fb.address);
            wd_q.push_back(fb.writedata);
        end
    end

`ifdef VGA_PIXEL_WRITER_CLEAR_EN
    logic               cmd_valid_s = 1'b0;
    logic [X_W-1:0]     cmd_x_s = '0;
    logic [Y_W-1:0]     cmd_y_s = '0;
    logic [COLOR_W-1:0] cmd_color_s = '0;
    logic               cmd_clear_s = 1'b0;
    logic               err_clr_s = 1'b0;
    logic [3:0]         status_s;
    logic [ADDR_W-1:0]  sa_q [$];
    logic [COLOR_W-1:0] sd_q [$];

    vga_pixel_writer_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) fb_s ();

    vga_pixel_writer #(
        .H_RES(4), .V_RES(2), .X_W(X_W), .Y_W(Y_W),
        .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
    ) dut_small (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid_s),
        .cmd_x     (cmd_x_s),
        .cmd_y     (cmd_y_s),
        .cmd_color (cmd_color_s),
        .cmd_clear (cmd_clear_s),
        .err_clr   (err_clr_s),
        .fb        (fb_s),
        .status    (status_s)
    );

    always @(posedge clk) begin
        if (!reset && fb_s.write && !fb_s.waitrequest) begin
            sa_q.push_back(fb_s.address);
            sd_q.push_back(fb_s.writedata);
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int x, input int y, input int c);
        cmd_valid = 1'b1;
        cmd_x     = X_W'(x);
        cmd_y     = Y_W'(y);
        cmd_color = COLOR_W'(c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fb.waitrequest = 1'b0;
`ifdef VGA_PIXEL_WRITER_CLEAR_EN
        fb_s.waitrequest = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        check("rst_status", 32'(status), 32'h0);
        check("rst_write", 32'(fb.write), 32'h0);
        check("rst_addr", 32'(fb.address), 32'h0);
        check("rst_data", 32'(fb.writedata), 32'h0);

        // Single pixel (10, 2): address 2*320+10 = 650, write in cycle 3.
        n0 = wa_q.size();
        send(10, 2, 'hA5);
        tick();
        cmd_valid = 1'b0;
        check("t1_c1_status", 32'(status), 32'h1);
        check("t1_c1_write", 32'(fb.write), 32'h0);
        tick();
        check("t1_c2_write", 32'(fb.write), 32'h0);
        tick();
        check("t1_c3_write", 32'(fb.write), 32'h1);
        check("t1_c3_addr", 32'(fb.address), 32'd650);
        check("t1_c3_data", 32'(fb.writedata), 32'hA5);
        tick();
        check("t1_c4_write", 32'(fb.write), 32'h0);
        check("t1_c4_status", 32'(status), 32'h2);
        check("t1_nwrites", 32'(wa_q.size()), 32'(n0 + 1));

        // Corner pixel with a 5-cycle stall: address 239*320+319 = 76799.
        n0 = wa_q.size();
        fb.waitrequest = 1'b1;
        send(319, 239, 'h5A);
        tick();
        cmd_valid = 1'b0;
        check("t2_c1_status", 32'(status), 32'h1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_write", 32'(fb.write), 32'h1);
            check("t2_stall_addr", 32'(fb.address), 32'd76799);
            tick();
        end
        fb.waitrequest = 1'b0;
        check("t2_rel_write", 32'(fb.write), 32'h1);
        check("t2_rel_addr", 32'(fb.address), 32'd76799);
        check("t2_rel_data", 32'(fb.writedata), 32'h5A);
        tick();
        check("t2_after_write", 32'(fb.write), 32'h0);
        check("t2_nwrites", 32'(wa_q.size()), 32'(n0 + 1));
        check("t2_logged_addr", 32'(wa_q[n0]), 32'd76799);

        // Out-of-range commands, sticky error and err_clr priority.
        n0 = wa_q.size();
        send(320, 0, 'h01);
        tick();
        send(0, 240, 'h02);
        check("t3_err_first", 32'(status), 32'hA);
        tick();
        cmd_valid = 1'b0;
        check("t3_err_second", 32'(status), 32'hA);
        check("t3_no_write", 32'(fb.write), 32'h0);
        tick();
        check("t3_nwrites", 32'(wa_q.size()), 32'(n0));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_err_cleared", 32'(status), 32'h2);
        send(400, 5, 'h03);
        err_clr = 1'b1;
        tick();
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        check("t3_set_wins", 32'(status), 32'hA);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_err_recleared", 32'(status), 32'h2);

        // Six back-to-back commands while stalled: first is popped, four fill the FIFO, sixth drops.
        n0 = wa_q.size();
        fb.waitrequest = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(i + 1, 1, 'h11 + i);
            if (i == 4) check("t4_not_full", 32'(status[STAT_FULL]), 32'h0);
            if (i == 5) check("t4_full", 32'(status[STAT_FULL]), 32'h1);
            tick();
        end
        cmd_valid = 1'b0;
        check("t4_status", 32'(status), 32'hD);
        fb.waitrequest = 1'b0;
        n = 0;
        while (status[STAT_BUSY] !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check("t4_drain_in_time", 32'(n < 40), 32'h1);
        check("t4_nwrites", 32'(wa_q.size()), 32'(n0 + 5));
        for (int i = 0; i < 5; i++) begin
            if (n0 + i < wa_q.size()) begin
                check("t4_addr", 32'(wa_q[n0 + i]), 32'(321 + i));
                check("t4_data", 32'(wd_q[n0 + i]), 32'(8'h11 + i));
            end
        end
        check("t4_final_status", 32'(status), 32'hA);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset during WRITE with one more command queued.
        fb.waitrequest = 1'b1;
        send(7, 3, 'h77);
        tick();
        send(8, 3, 'h78);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t5_in_write", 32'(fb.write), 32'h1);
        check("t5_in_write_addr", 32'(fb.address), 32'd967);
        reset = 1'b1;
        tick();
        check("t5_rst_write", 32'(fb.write), 32'h0);
        check("t5_rst_status", 32'(status), 32'h0);
        check("t5_rst_addr", 32'(fb.address), 32'h0);
        reset = 1'b0;
        fb.waitrequest = 1'b0;
        n0 = wa_q.size();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_flushed_write", 32'(fb.write), 32'h0);
        end
        check("t5_flushed_status", 32'(status), 32'h0);
        check("t5_flushed_nwrites", 32'(wa_q.size()), 32'(n0));
        send(2, 1, 'h42);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("t5_new_write", 32'(fb.write), 32'h1);
        check("t5_new_addr", 32'(fb.address), 32'd322);
        check("t5_new_data", 32'(fb.writedata), 32'h42);
        tick();
        check("t5_new_nwrites", 32'(wa_q.size()), 32'(n0 + 1));
        check("t5_new_status", 32'(status), 32'h2);

`ifdef VGA_PIXEL_WRITER_CLEAR_EN
        // 4x2 clear with a stall, a rejected second clear and a pixel queued during the clear.
        n0 = sa_q.size();
        cmd_clear_s = 1'b1;
        cmd_color_s = 8'h3C;
        tick();
        cmd_clear_s = 1'b0;
        check("clr_c1_write", 32'(fb_s.write), 32'h1);
        check("clr_c1_addr", 32'(fb_s.address), 32'h0);
        check("clr_c1_data", 32'(fb_s.writedata), 32'h3C);
        check("clr_c1_status", 32'(status_s), 32'h1);
        cmd_clear_s = 1'b1;
        cmd_valid_s = 1'b1;
        cmd_x_s     = 9'd1;
        cmd_y_s     = 8'd1;
        cmd_color_s = 8'h99;
        tick();
        cmd_clear_s = 1'b0;
        cmd_valid_s = 1'b0;
        check("clr_busy_err", 32'(status_s[STAT_ERR]), 32'h1);
        fb_s.waitrequest = 1'b1;
        tick();
        fb_s.waitrequest = 1'b0;
        n = 0;
        while (status_s[STAT_BUSY] !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check("clr_drain_in_time", 32'(n < 50), 32'h1);
        check("clr_nwrites", 32'(sa_q.size()), 32'(n0 + 9));
        for (int i = 0; i < 8; i++) begin
            if (n0 + i < sa_q.size()) begin
                check("clr_addr", 32'(sa_q[n0 + i]), 32'(i));
                check("clr_data", 32'(sd_q[n0 + i]), 32'h3C);
            end
        end
        if (n0 + 8 < sa_q.size()) begin
            check("clr_queued_addr", 32'(sa_q[n0 + 8]), 32'd5);
            check("clr_queued_data", 32'(sd_q[n0 + 8]), 32'h99);
        end
        check("clr_final_status", 32'(status_s), 32'hA);
`else
        // Without the clear feature cmd_clear has no effect.
        n0 = wa_q.size();
        cmd_clear = 1'b1;
        cmd_color = 8'h3C;
        tick();
        cmd_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("noclr_write", 32'(fb.write), 32'h0);
            tick();
        end
        check("noclr_status", 32'(status), 32'h2);
        check("noclr_nwrites", 32'(wa_q.size()), 32'(n0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
